// File: rtl/rename_regfile_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rename_regfile_if : decode/read/write-back/commit bundle of the RRF    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface rename_regfile_if #(
  parameter int DATA_W    = 32,
  parameter int ARCH_REGS = 32,
  parameter int RRF_DEPTH = 16
);
  localparam int AW = $clog2(ARCH_REGS);
  localparam int TW = $clog2(RRF_DEPTH);

  logic              map_en_a, map_en_b;
  logic [AW-1:0]     map_addr_a, map_addr_b;
  logic [TW-1:0]     map_tag_a, map_tag_b;
  logic              map_stall;
  logic [TW:0]       free_cnt;
  logic [AW-1:0]     rd_addr_a0, rd_addr_a1, rd_addr_b0, rd_addr_b1;
  logic [DATA_W-1:0] rd_data_a0, rd_data_a1, rd_data_b0, rd_data_b1;
  logic              rd_ready_a0, rd_ready_a1, rd_ready_b0, rd_ready_b1;
  logic [TW-1:0]     rd_tag_a0, rd_tag_a1, rd_tag_b0, rd_tag_b1;
  logic              wb_en_a, wb_en_b;
  logic [TW-1:0]     wb_tag_a, wb_tag_b;
  logic [DATA_W-1:0] wb_data_a, wb_data_b;
  logic              cm_en_a, cm_en_b;
  logic              flush;

  modport master (
    output map_en_a, map_en_b, map_addr_a, map_addr_b,
    output rd_addr_a0, rd_addr_a1, rd_addr_b0, rd_addr_b1,
    output wb_en_a, wb_en_b, wb_tag_a, wb_tag_b, wb_data_a, wb_data_b,
    output cm_en_a, cm_en_b, flush,
    input  map_tag_a, map_tag_b, map_stall, free_cnt,
    input  rd_data_a0, rd_data_a1, rd_data_b0, rd_data_b1,
    input  rd_ready_a0, rd_ready_a1, rd_ready_b0, rd_ready_b1,
    input  rd_tag_a0, rd_tag_a1, rd_tag_b0, rd_tag_b1
  );

  modport slave (
    input  map_en_a, map_en_b, map_addr_a, map_addr_b,
    input  rd_addr_a0, rd_addr_a1, rd_addr_b0, rd_addr_b1,
    input  wb_en_a, wb_en_b, wb_tag_a, wb_tag_b, wb_data_a, wb_data_b,
    input  cm_en_a, cm_en_b, flush,
    output map_tag_a, map_tag_b, map_stall, free_cnt,
    output rd_data_a0, rd_data_a1, rd_data_b0, rd_data_b1,
    output rd_ready_a0, rd_ready_a1, rd_ready_b0, rd_ready_b1,
    output rd_tag_a0, rd_tag_a1, rd_tag_b0, rd_tag_b1
  );
endinterface
`default_nettype wire

// File: rtl/rename_regfile.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rename_regfile : dual-lane ARF with circular rename buffer, in-order   |
// | commit and full flush.                                    Rev 1.0      |
// +-----------------------------------------------------------------------+
module rename_regfile #(
  parameter int DATA_W    = 32,
  parameter int ARCH_REGS = 32,
  parameter int RRF_DEPTH = 16
) (
  input logic             clk,
  input logic             rst,
  rename_regfile_if.slave bus
);
  localparam int AW = $clog2(ARCH_REGS);
  localparam int TW = $clog2(RRF_DEPTH);
  localparam int CW = TW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(RRF_DEPTH);

  logic [DATA_W-1:0]    arf_q [ARCH_REGS];
  logic [DATA_W-1:0]    arf_d [ARCH_REGS];
  logic [ARCH_REGS-1:0] busy_q, busy_d;
  logic [TW-1:0]        arch_tag_q [ARCH_REGS];
  logic [TW-1:0]        arch_tag_d [ARCH_REGS];
  logic [RRF_DEPTH-1:0] rrf_valid_q, rrf_valid_d;
  logic [RRF_DEPTH-1:0] rrf_ready_q, rrf_ready_d;
  logic [DATA_W-1:0]    rrf_data_q [RRF_DEPTH];
  logic [DATA_W-1:0]    rrf_data_d [RRF_DEPTH];
  logic [AW-1:0]        rrf_dest_q [RRF_DEPTH];
  logic [AW-1:0]        rrf_dest_d [RRF_DEPTH];
  logic [TW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        free_cnt_q, free_cnt_d;

  // Allocation is all-or-nothing against the pre-commit free count.
  logic          need_a, need_b, alloc_a, alloc_b, stall;
  logic [CW-1:0] needs;
  logic [TW-1:0] tag_a, tag_b;

  always_comb begin
    need_a  = bus.map_en_a && (bus.map_addr_a != '0);
    need_b  = bus.map_en_b && (bus.map_addr_b != '0);
    needs   = CW'(need_a) + CW'(need_b);
    stall   = needs > free_cnt_q;
    alloc_a = need_a && !stall;
    alloc_b = need_b && !stall;
    tag_a   = tail_q;
    tag_b   = need_a ? tail_q + TW'(1) : tail_q;
  end

  assign bus.map_stall = stall;
  assign bus.map_tag_a = alloc_a ? tag_a : '0;
  assign bus.map_tag_b = alloc_b ? tag_b : '0;
  assign bus.free_cnt  = free_cnt_q;

  logic [AW-1:0]     rd_addr  [4];
  logic [DATA_W-1:0] rd_data  [4];
  logic              rd_ready [4];
  logic [TW-1:0]     rd_tag   [4];

  assign rd_addr[0] = bus.rd_addr_a0;
  assign rd_addr[1] = bus.rd_addr_a1;
  assign rd_addr[2] = bus.rd_addr_b0;
  assign rd_addr[3] = bus.rd_addr_b1;

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rd_data[p]  = '0;
      rd_ready[p] = 1'b1;
      rd_tag[p]   = '0;
      if (rd_addr[p] != '0) begin
        if (!busy_q[rd_addr[p]]) begin
          rd_data[p] = arf_q[rd_addr[p]];
        end else if (rrf_ready_q[arch_tag_q[rd_addr[p]]]) begin
          rd_data[p] = rrf_data_q[arch_tag_q[rd_addr[p]]];
        end else begin
          rd_ready[p] = 1'b0;
          rd_tag[p]   = arch_tag_q[rd_addr[p]];
        end
      end
      // Lane B sources see lane A's destination renamed in the same bundle.
      if ((p >= 2) && alloc_a && (rd_addr[p] == bus.map_addr_a)) begin
        rd_data[p]  = '0;
        rd_ready[p] = 1'b0;
        rd_tag[p]   = tag_a;
      end
    end
  end

  assign bus.rd_data_a0  = rd_data[0];
  assign bus.rd_data_a1  = rd_data[1];
  assign bus.rd_data_b0  = rd_data[2];
  assign bus.rd_data_b1  = rd_data[3];
  assign bus.rd_ready_a0 = rd_ready[0];
  assign bus.rd_ready_a1 = rd_ready[1];
  assign bus.rd_ready_b0 = rd_ready[2];
  assign bus.rd_ready_b1 = rd_ready[3];
  assign bus.rd_tag_a0   = rd_tag[0];
  assign bus.rd_tag_a1   = rd_tag[1];
  assign bus.rd_tag_b0   = rd_tag[2];
  assign bus.rd_tag_b1   = rd_tag[3];

  // Second retire only follows a successful first one.
  logic          rt_en  [2];
  logic [TW-1:0] rt_tag [2];

  always_comb begin
    rt_tag[0] = head_q;
    rt_tag[1] = head_q + TW'(1);
    rt_en[0]  = bus.cm_en_a && rrf_valid_q[rt_tag[0]] && rrf_ready_q[rt_tag[0]];
    rt_en[1]  = rt_en[0] && bus.cm_en_b && rrf_valid_q[rt_tag[1]] && rrf_ready_q[rt_tag[1]];
  end

  always_comb begin
    arf_d       = arf_q;
    busy_d      = busy_q;
    arch_tag_d  = arch_tag_q;
    rrf_valid_d = rrf_valid_q;
    rrf_ready_d = rrf_ready_q;
    rrf_data_d  = rrf_data_q;
    rrf_dest_d  = rrf_dest_q;
    head_d      = head_q + TW'(rt_en[0]) + TW'(rt_en[1]);
    tail_d      = tail_q + TW'(alloc_a) + TW'(alloc_b);
    free_cnt_d  = free_cnt_q - CW'(alloc_a) - CW'(alloc_b) + CW'(rt_en[0]) + CW'(rt_en[1]);

    if (bus.wb_en_a && rrf_valid_q[bus.wb_tag_a]) begin
      rrf_data_d[bus.wb_tag_a]  = bus.wb_data_a;
      rrf_ready_d[bus.wb_tag_a] = 1'b1;
    end
    if (bus.wb_en_b && rrf_valid_q[bus.wb_tag_b]) begin
      rrf_data_d[bus.wb_tag_b]  = bus.wb_data_b;
      rrf_ready_d[bus.wb_tag_b] = 1'b1;
    end

    for (int k = 0; k < 2; k++) begin
      if (rt_en[k]) begin
        arf_d[rrf_dest_q[rt_tag[k]]] = rrf_data_q[rt_tag[k]];
        rrf_valid_d[rt_tag[k]]       = 1'b0;
        if (arch_tag_q[rrf_dest_q[rt_tag[k]]] == rt_tag[k]) begin
          busy_d[rrf_dest_q[rt_tag[k]]] = 1'b0;
        end
      end
    end

    // Maps come last so a same-cycle rename keeps the register busy.
    if (alloc_a) begin
      rrf_valid_d[tag_a]        = 1'b1;
      rrf_ready_d[tag_a]        = 1'b0;
      rrf_dest_d[tag_a]         = bus.map_addr_a;
      busy_d[bus.map_addr_a]     = 1'b1;
      arch_tag_d[bus.map_addr_a] = tag_a;
    end
    if (alloc_b) begin
      rrf_valid_d[tag_b]        = 1'b1;
      rrf_ready_d[tag_b]        = 1'b0;
      rrf_dest_d[tag_b]         = bus.map_addr_b;
      busy_d[bus.map_addr_b]     = 1'b1;
      arch_tag_d[bus.map_addr_b] = tag_b;
    end

    if (bus.flush) begin
      arf_d       = arf_q;
      busy_d      = '0;
      rrf_valid_d = '0;
      head_d      = '0;
      tail_d      = '0;
      free_cnt_d  = DEPTH_CNT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        arf_q[i]      <= '0;
        arch_tag_q[i] <= '0;
      end
      for (int i = 0; i < RRF_DEPTH; i++) begin
        rrf_data_q[i] <= '0;
        rrf_dest_q[i] <= '0;
      end
      busy_q      <= '0;
      rrf_valid_q <= '0;
      rrf_ready_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      free_cnt_q  <= DEPTH_CNT;
    end else begin
      arf_q       <= arf_d;
      arch_tag_q  <= arch_tag_d;
      rrf_data_q  <= rrf_data_d;
      rrf_dest_q  <= rrf_dest_d;
      busy_q      <= busy_d;
      rrf_valid_q <= rrf_valid_d;
      rrf_ready_q <= rrf_ready_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      free_cnt_q  <= free_cnt_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rename_regfile.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_rename_regfile : vector table, directed sequences and random ops    |
// | against a queue-based model.                              Rev 1.0      |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_rename_regfile;
  localparam int DATA_W = 32, ARCH_REGS = 32, RRF_DEPTH = 16;
  localparam int AW = 5, TW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rename_regfile_if #(.DATA_W(DATA_W), .ARCH_REGS(ARCH_REGS), .RRF_DEPTH(RRF_DEPTH)) bus ();
  rename_regfile #(.DATA_W(DATA_W), .ARCH_REGS(ARCH_REGS), .RRF_DEPTH(RRF_DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic map_en_a; logic [AW-1:0] map_addr_a;
    logic map_en_b; logic [AW-1:0] map_addr_b;
    logic [AW-1:0] rd_a0, rd_a1, rd_b0, rd_b1;
    logic wb_en_a; logic [TW-1:0] wb_tag_a; logic [31:0] wb_data_a;
    logic wb_en_b; logic [TW-1:0] wb_tag_b; logic [31:0] wb_data_b;
    logic cm_en_a, cm_en_b, flush;
  } in_t;

  typedef struct packed {
    in_t in;
    logic e_stall; logic [TW-1:0] e_tag_a, e_tag_b; logic [TW:0] e_free;
    logic e_rdy_a0; logic [31:0] e_dat_a0; logic e_rdy_b0; logic [TW-1:0] e_tag_b0;
  } vec_t;

  typedef struct { int tag; int dest; bit rdy; logic [31:0] data; } ent_t;

  int checks = 0;
  int errors = 0;

  // Reference model: ordered list of in-flight entries plus a rename table.
  ent_t        q[$];
  logic [31:0] m_arf  [ARCH_REGS];
  bit          m_busy [ARCH_REGS];
  int          m_tag  [ARCH_REGS];
  int          m_tail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    q.delete();
    for (int i = 0; i < ARCH_REGS; i++) begin
      m_arf[i] = '0; m_busy[i] = 0; m_tag[i] = 0;
    end
    m_tail = 0;
  endfunction

  function automatic void m_read(input int addr, input bit ovr, input int otag,
                                 output logic [31:0] d, output bit r, output int t);
    d = '0; r = 1; t = 0;
    if (ovr) begin r = 0; t = otag; end
    else if (addr != 0 && m_busy[addr]) begin
      foreach (q[i]) if (q[i].tag == m_tag[addr]) begin
        if (q[i].rdy) d = q[i].data;
        else begin r = 0; t = m_tag[addr]; end
      end
    end else if (addr != 0) d = m_arf[addr];
  endfunction

  function automatic void m_retire();
    ent_t e = q.pop_front();
    m_arf[e.dest] = e.data;
    if (m_tag[e.dest] == e.tag) m_busy[e.dest] = 0;
  endfunction

  function automatic void m_update(input in_t x, input bit aa, input bit ab, input int ta, input int tb);
    if (x.flush) begin
      q.delete();
      for (int i = 0; i < ARCH_REGS; i++) m_busy[i] = 0;
      m_tail = 0;
      return;
    end
    if (x.cm_en_a && q.size() > 0 && q[0].rdy) begin
      m_retire();
      if (x.cm_en_b && q.size() > 0 && q[0].rdy) m_retire();
    end
    foreach (q[i]) if (x.wb_en_a && q[i].tag == int'(x.wb_tag_a)) begin q[i].rdy = 1; q[i].data = x.wb_data_a; end
    foreach (q[i]) if (x.wb_en_b && q[i].tag == int'(x.wb_tag_b)) begin q[i].rdy = 1; q[i].data = x.wb_data_b; end
    if (aa) begin q.push_back('{ta, int'(x.map_addr_a), 0, '0}); m_busy[x.map_addr_a] = 1; m_tag[x.map_addr_a] = ta; end
    if (ab) begin q.push_back('{tb, int'(x.map_addr_b), 0, '0}); m_busy[x.map_addr_b] = 1; m_tag[x.map_addr_b] = tb; end
    m_tail = (m_tail + int'(aa) + int'(ab)) % RRF_DEPTH;
  endfunction

  task automatic drive(input in_t x);
    bus.map_en_a = x.map_en_a;  bus.map_addr_a = x.map_addr_a;
    bus.map_en_b = x.map_en_b;  bus.map_addr_b = x.map_addr_b;
    bus.rd_addr_a0 = x.rd_a0;   bus.rd_addr_a1 = x.rd_a1;
    bus.rd_addr_b0 = x.rd_b0;   bus.rd_addr_b1 = x.rd_b1;
    bus.wb_en_a = x.wb_en_a;    bus.wb_tag_a = x.wb_tag_a;  bus.wb_data_a = x.wb_data_a;
    bus.wb_en_b = x.wb_en_b;    bus.wb_tag_b = x.wb_tag_b;  bus.wb_data_b = x.wb_data_b;
    bus.cm_en_a = x.cm_en_a;    bus.cm_en_b = x.cm_en_b;    bus.flush = x.flush;
  endtask

  // One clock: drive at edge+1, compare against the model at the falling edge, then update the model.
  task automatic cycle(input in_t x);
    bit na, nb, st, ovr, r;
    int free, ta, tb, t;
    int addr [4];
    logic [31:0] d;
    logic [31:0] ad [4];
    logic ar [4];
    logic [TW-1:0] at [4];
    drive(x);
    #4;
    na = x.map_en_a && x.map_addr_a != 0;
    nb = x.map_en_b && x.map_addr_b != 0;
    free = RRF_DEPTH - q.size();
    st = (int'(na) + int'(nb)) > free;
    ta = m_tail;
    tb = (m_tail + int'(na)) % RRF_DEPTH;
    chk("map_stall", 64'(bus.map_stall), 64'(st));
    chk("free_cnt", 64'(bus.free_cnt), 64'(free));
    if (na && !st) chk("map_tag_a", 64'(bus.map_tag_a), 64'(ta));
    if (nb && !st) chk("map_tag_b", 64'(bus.map_tag_b), 64'(tb));
    if (x.map_en_a && x.map_addr_a == 0) chk("map_tag_a_x0", 64'(bus.map_tag_a), 64'd0);
    if (x.map_en_b && x.map_addr_b == 0) chk("map_tag_b_x0", 64'(bus.map_tag_b), 64'd0);
    addr[0] = x.rd_a0; addr[1] = x.rd_a1; addr[2] = x.rd_b0; addr[3] = x.rd_b1;
    ad[0] = bus.rd_data_a0;  ad[1] = bus.rd_data_a1;  ad[2] = bus.rd_data_b0;  ad[3] = bus.rd_data_b1;
    ar[0] = bus.rd_ready_a0; ar[1] = bus.rd_ready_a1; ar[2] = bus.rd_ready_b0; ar[3] = bus.rd_ready_b1;
    at[0] = bus.rd_tag_a0;   at[1] = bus.rd_tag_a1;   at[2] = bus.rd_tag_b0;   at[3] = bus.rd_tag_b1;
    for (int p = 0; p < 4; p++) begin
      ovr = (p >= 2) && na && !st && (addr[p] == int'(x.map_addr_a));
      m_read(addr[p], ovr, ta, d, r, t);
      chk($sformatf("rd%0d_ready x%0d", p, addr[p]), 64'(ar[p]), 64'(r));
      chk($sformatf("rd%0d_data x%0d", p, addr[p]), 64'(ad[p]), 64'(d));
      chk($sformatf("rd%0d_tag x%0d", p, addr[p]), 64'(at[p]), 64'(t));
    end
    @(posedge clk);
    #1;
    m_update(x, na && !st, nb && !st, ta, tb);
  endtask

  task automatic do_reset();
    drive('0);
    rst = 1'b1;
    m_reset();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic in_t rnd();
    in_t x = '0;
    x.map_en_a   = ($urandom_range(0, 1) == 0);
    x.map_addr_a = AW'($urandom_range(0, 7));
    x.map_en_b   = ($urandom_range(0, 1) == 0);
    x.map_addr_b = AW'($urandom_range(0, 7));
    x.rd_a0 = AW'($urandom_range(0, 9)); x.rd_a1 = AW'($urandom_range(0, 9));
    x.rd_b0 = AW'($urandom_range(0, 9)); x.rd_b1 = AW'($urandom_range(0, 9));
    if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
      x.wb_en_a = 1; x.wb_tag_a = TW'(q[$urandom_range(0, q.size() - 1)].tag); x.wb_data_a = $urandom;
    end
    if ($urandom_range(0, 1) == 0) begin
      x.wb_en_b = 1; x.wb_tag_b = TW'($urandom_range(0, RRF_DEPTH - 1)); x.wb_data_b = $urandom;
    end
    x.cm_en_a = ($urandom_range(0, 2) != 0);
    x.cm_en_b = ($urandom_range(0, 1) == 0);
    x.flush   = ($urandom_range(0, 59) == 0);
    return x;
  endfunction

  vec_t vecs [8];
  in_t  x;

  initial begin
    vecs[0] = '{in: '{rd_b0: 5'd5, default: '0}, e_stall: 0, e_tag_a: 0, e_tag_b: 0, e_free: 16, e_rdy_a0: 1, e_dat_a0: 0, e_rdy_b0: 1, e_tag_b0: 0};
    vecs[1] = '{in: '{map_en_a: 1, map_addr_a: 5'd3, map_en_b: 1, map_addr_b: 5'd4, rd_a0: 5'd3, rd_b0: 5'd4, default: '0}, e_stall: 0, e_tag_a: 0, e_tag_b: 1, e_free: 16, e_rdy_a0: 1, e_dat_a0: 0, e_rdy_b0: 1, e_tag_b0: 0};
    vecs[2] = '{in: '{rd_a0: 5'd3, rd_b0: 5'd4, wb_en_a: 1, wb_tag_a: 4'd0, wb_data_a: 32'hDEADBEEF, default: '0}, e_stall: 0, e_tag_a: 0, e_tag_b: 0, e_free: 14, e_rdy_a0: 0, e_dat_a0: 0, e_rdy_b0: 0, e_tag_b0: 1};
    vecs[3] = '{in: '{map_en_a: 1, map_addr_a: 5'd7, rd_a0: 5'd3, rd_b0: 5'd7, default: '0}, e_stall: 0, e_tag_a: 2, e_tag_b: 0, e_free: 14, e_rdy_a0: 1, e_dat_a0: 32'hDEADBEEF, e_rdy_b0: 0, e_tag_b0: 2};
    vecs[4] = '{in: '{map_en_a: 1, map_addr_a: 5'd9, map_en_b: 1, map_addr_b: 5'd9, rd_a0: 5'd7, rd_b0: 5'd9, default: '0}, e_stall: 0, e_tag_a: 3, e_tag_b: 4, e_free: 13, e_rdy_a0: 0, e_dat_a0: 0, e_rdy_b0: 0, e_tag_b0: 3};
    vecs[5] = '{in: '{rd_a0: 5'd9, rd_b0: 5'd9, wb_en_b: 1, wb_tag_b: 4'd4, wb_data_b: 32'h1234, default: '0}, e_stall: 0, e_tag_a: 0, e_tag_b: 0, e_free: 11, e_rdy_a0: 0, e_dat_a0: 0, e_rdy_b0: 0, e_tag_b0: 4};
    vecs[6] = '{in: '{rd_a0: 5'd9, rd_b0: 5'd3, cm_en_a: 1, cm_en_b: 1, default: '0}, e_stall: 0, e_tag_a: 0, e_tag_b: 0, e_free: 11, e_rdy_a0: 1, e_dat_a0: 32'h1234, e_rdy_b0: 1, e_tag_b0: 0};
    vecs[7] = '{in: '{rd_a0: 5'd3, rd_b0: 5'd4, default: '0}, e_stall: 0, e_tag_a: 0, e_tag_b: 0, e_free: 12, e_rdy_a0: 1, e_dat_a0: 32'hDEADBEEF, e_rdy_b0: 0, e_tag_b0: 1};

    rst = 1'b1;
    drive('0);
    m_reset();
    #12 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].in);
      #1;
      chk($sformatf("v%0d stall", i), 64'(bus.map_stall), 64'(vecs[i].e_stall));
      chk($sformatf("v%0d free", i), 64'(bus.free_cnt), 64'(vecs[i].e_free));
      if (vecs[i].in.map_en_a) chk($sformatf("v%0d tag_a", i), 64'(bus.map_tag_a), 64'(vecs[i].e_tag_a));
      if (vecs[i].in.map_en_b) chk($sformatf("v%0d tag_b", i), 64'(bus.map_tag_b), 64'(vecs[i].e_tag_b));
      chk($sformatf("v%0d rdy_a0", i), 64'(bus.rd_ready_a0), 64'(vecs[i].e_rdy_a0));
      chk($sformatf("v%0d dat_a0", i), 64'(bus.rd_data_a0), 64'(vecs[i].e_dat_a0));
      chk($sformatf("v%0d rdy_b0", i), 64'(bus.rd_ready_b0), 64'(vecs[i].e_rdy_b0));
      chk($sformatf("v%0d tag_b0", i), 64'(bus.rd_tag_b0), 64'(vecs[i].e_tag_b0));
      cycle(vecs[i].in);
    end

    // Fill to one free slot, refuse a dual map, then wrap the tail.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      x = '0; x.map_en_a = 1; x.map_addr_a = AW'(i % 7 + 1);
      cycle(x);
    end
    x = '0; x.map_en_a = 1; x.map_addr_a = 5'd1; x.map_en_b = 1; x.map_addr_b = 5'd2;
    drive(x);
    #1;
    chk("full_stall", 64'(bus.map_stall), 64'd1);
    cycle(x);
    chk("free_after_stall", 64'(bus.free_cnt), 64'd1);
    x = '0; x.map_en_a = 1; x.map_addr_a = 5'd5; x.wb_en_a = 1; x.wb_tag_a = 4'd0; x.wb_data_a = 32'hA5;
    drive(x);
    #1;
    chk("last_tag", 64'(bus.map_tag_a), 64'd15);
    cycle(x);
    chk("free_full", 64'(bus.free_cnt), 64'd0);
    x = '0; x.cm_en_a = 1; x.map_en_a = 1; x.map_addr_a = 5'd6;
    cycle(x);
    x = '0; x.map_en_a = 1; x.map_addr_a = 5'd6; x.rd_a0 = 5'd1;
    drive(x);
    #1;
    chk("wrap_tag", 64'(bus.map_tag_a), 64'd0);
    cycle(x);

    // Commit racing a re-map of the same register, then flush with a pending commit.
    do_reset();
    x = '0; x.map_en_a = 1; x.map_addr_a = 5'd3; cycle(x);
    x = '0; x.wb_en_a = 1; x.wb_tag_a = 4'd0; x.wb_data_a = 32'h55; cycle(x);
    x = '0; x.cm_en_a = 1; x.map_en_a = 1; x.map_addr_a = 5'd3; cycle(x);
    chk("free_commit_map", 64'(bus.free_cnt), 64'd15);
    x = '0; x.map_en_a = 1; x.map_addr_a = 5'd10; x.map_en_b = 1; x.map_addr_b = 5'd11; x.rd_a0 = 5'd3;
    drive(x);
    #1;
    chk("x3_still_busy", 64'(bus.rd_ready_a0), 64'd0);
    chk("x3_new_tag", 64'(bus.rd_tag_a0), 64'd1);
    cycle(x);
    x = '0; x.map_en_a = 1; x.map_addr_a = 5'd12; x.map_en_b = 1; x.map_addr_b = 5'd13; cycle(x);
    x = '0; x.map_en_a = 1; x.map_addr_a = 5'd14; x.wb_en_a = 1; x.wb_tag_a = 4'd1; x.wb_data_a = 32'h77; cycle(x);
    chk("six_valid", 64'(bus.free_cnt), 64'd10);
    x = '0; x.flush = 1; x.cm_en_a = 1; cycle(x);
    x = '0; x.map_en_a = 1; x.map_addr_a = 5'd20; x.rd_a0 = 5'd3; x.rd_b0 = 5'd10;
    drive(x);
    #1;
    chk("flush_free", 64'(bus.free_cnt), 64'd16);
    chk("flush_x3_ready", 64'(bus.rd_ready_a0), 64'd1);
    chk("flush_x3_arf", 64'(bus.rd_data_a0), 64'h55);
    chk("flush_x10_ready", 64'(bus.rd_ready_b0), 64'd1);
    chk("flush_tag0", 64'(bus.map_tag_a), 64'd0);
    cycle(x);

    for (int n = 0; n < 600; n++) cycle(rnd());

    // Asynchronous reset between edges clears state without a clock.
    drive('0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_free", 64'(bus.free_cnt), 64'd16);
    chk("async_stall", 64'(bus.map_stall), 64'd0);
    m_reset();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    x = '0; x.rd_a0 = 5'd1; x.rd_a1 = 5'd2; x.rd_b0 = 5'd3; x.rd_b1 = 5'd4; cycle(x);
    for (int n = 0; n < 100; n++) cycle(rnd());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
Dual-lane register file with a parametrised circular rename buffer (RRF). It allocates destination tags at decode and serves four source reads with ready/tag status. It accepts out-of-order execution write-back by tag and retires entries in order into the architectural file (ARF). The block sits between decode and the reservation stations, and adds in-order commit, tag output and full flush.

Parameters:
DATA_W, 32, register data width
ARCH_REGS, 32, architectural register count; register 0 is hardwired zero
RRF_DEPTH, 16, rename-buffer entries; must be a power of two and at least 2
AW/TW (localparam), clog2(ARCH_REGS)/clog2(RRF_DEPTH), arch address / tag widths

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
map_en_a, map_en_b  in  1  request destination allocation for lane A/B
map_addr_a, map_addr_b  in  AW  arch destination to rename
map_tag_a, map_tag_b  out  TW  allocated tag (combinational, valid when enabled and not stalled)
map_stall  out  1  allocation refused this cycle (all-or-nothing)
free_cnt  out  TW+1  free RRF entries
rd_addr_a0/a1/b0/b1  in  AW  source read addresses
rd_data_a0/a1/b0/b1  out  DATA_W  read data (0 when not ready)
rd_ready_a0/a1/b0/b1  out  1  data valid
rd_tag_a0/a1/b0/b1  out  TW  producing tag when not ready, else 0
wb_en_a, wb_en_b  in  1  execution result write
wb_tag_a, wb_tag_b  in  TW  target RRF entry
wb_data_a, wb_data_b  in  DATA_W  result
cm_en_a, cm_en_b  in  1  commit oldest entry / second-oldest entry
flush  in  1  discard all speculative state

Behaviour:
- Reset: ARF data 0, all busy bits 0, all RRF entries invalid, head=tail=0, free_cnt=RRF_DEPTH.
  - After reset, reads return data 0, ready 1, tag 0. map_stall is 0 unless a map request exceeds free entries.
- Allocation needs = (map_en_a && map_addr_a!=0) + (map_en_b && map_addr_b!=0).
  - map_stall = needs > free_cnt, using free_cnt before this cycle's commits. Freed entries become usable the next cycle.
  - On stall, neither lane allocates.
- Tags are assigned from tail in order: lane A gets tail, lane B gets tail+1 (or tail if A did not allocate).
  - Indices wrap modulo RRF_DEPTH.
  - On the clock edge: the entry is marked valid with ready=0 and its arch destination stored; busy[dest]=1 and arch_tag[dest]=tag; tail advances.
  - If both lanes map the same destination, lane B's tag is left in the table.
  - A map to register 0 allocates nothing and sets map_tag=0.
- Reads are combinational on pre-edge state.
  - Address 0: data 0, ready 1.
  - Register not busy: ARF data, ready 1.
  - Register busy and its RRF entry ready: RRF data, ready 1.
  - Otherwise: ready 0, data 0, tag=arch_tag.
  - Intra-bundle override: if rd_addr_b0/b1 equals lane A's allocating destination, lane B's read returns ready 0 and tag=map_tag_a.
- Write-back: on the edge, entry data is written and ready=1. It is ignored if the entry is invalid. If both lanes write the same tag, lane B wins.
  - A write-back and a read in the same cycle are not bypassed; the result is visible next cycle.
- Commit: cm_en_a retires head; cm_en_b (only together with cm_en_a) also retires head+1. cm_en_b alone is ignored.
  - Committing an invalid or not-ready entry is a protocol error. It is ignored, and no later entry in the same cycle retires.
  - On retire: ARF[dest] is written with the entry data and the entry is invalidated; head advances.
  - busy[dest] is cleared only if arch_tag[dest] equals the retiring tag and no same-cycle map targets dest (a same-cycle map wins).
- free_cnt is updated each edge: free_cnt - allocated + retired.
- flush has priority over map, write-back and commit in the same cycle.
  - All RRF entries are invalidated, all busy bits cleared, head=tail=0, free_cnt=RRF_DEPTH.
  - ARF contents are kept. A same-cycle commit is discarded.
- An asynchronous reset asserted mid-operation returns all state to reset values immediately.

Test Plan:
- Reset, then read x0 and x5 → data 0, ready 1. free_cnt=16, map_stall=0.
- Map A→x3, B→x4 → tags 0 and 1, free_cnt=14. Next cycle read x3 → ready 0, tag 0. wb tag0=0xDEADBEEF; next cycle read x3 → ready 1, data 0xDEADBEEF.
- Same-cycle map A→x7 with rd_addr_b0=x7 → rd_ready_b0=0, rd_tag_b0=map_tag_a. Map A and B both →x9 → arch_tag[x9]=lane B's tag.
- Fill 15 entries, then map_en_a and map_en_b both to nonzero destinations → map_stall=1, no allocation, free_cnt stays 1. Single map succeeds and wraps tail to 0.
- Commit head (ready, dest x3, data 0x55) together with a new map to x3 → ARF[x3]=0x55, x3 remains busy with the new tag, free_cnt unchanged (+1 retired, -1 allocated).
- With 6 entries valid, assert flush together with cm_en_a → all reads ready with pre-flush ARF data, free_cnt=16, next allocation tag 0.
